// File: rtl/eventos_boton_if.sv
// Button event bundle: debounced level and repeat enable in, one-cycle event pulses and held level out.
interface eventos_boton_if;
  logic db;
  logic repeat_en;
  logic press_tick;
  logic release_tick;
  logic long_tick;
  logic repeat_tick;
  logic held;

  modport master (
    output db, repeat_en,
    input  press_tick, release_tick, long_tick, repeat_tick, held
  );

  modport slave (
    input  db, repeat_en,
    output press_tick, release_tick, long_tick, repeat_tick, held
  );
endinterface

// File: rtl/eventos_boton.sv
// Turns the debounced button level into press, release, long-press and auto-repeat pulses.
module eventos_boton #(
  parameter int unsigned CW            = 26,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic            clk,
  input  logic            reset,
  eventos_boton_if.slave  btn
);

  localparam logic [CW-1:0] LONG_TERM   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_TERM = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    PRESSED,
    REPEAT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            repeat_q, repeat_d;
  logic            held_q, held_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      // A button still down after reset must be released before it can count.
      WAIT_LOW: begin
        if (!btn.db) state_d = IDLE;
      end
      IDLE: begin
        if (btn.db) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn.db) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == LONG_TERM) begin
          state_d = REPEAT;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!btn.db) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == REPEAT_TERM) begin
          // Cadence keeps running while repeat is disabled, so enabling it keeps phase.
          cnt_d    = '0;
          repeat_d = btn.repeat_en;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOW;
    endcase

    held_d = (state_d == PRESSED) || (state_d == REPEAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_LOW;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign btn.press_tick   = press_q;
  assign btn.release_tick = release_q;
  assign btn.long_tick    = long_q;
  assign btn.repeat_tick  = repeat_q;
  assign btn.held         = held_q;

endmodule

// File: tb/tb_eventos_boton.sv
// Directed bench for eventos_boton with LONG_CYCLES=8, REPEAT_CYCLES=4, CW=4.
module tb_eventos_boton;

  logic clk;
  logic reset;
  int unsigned n_cmp;
  int unsigned n_bad;

  eventos_boton_if bus ();

  eventos_boton #(
    .CW            (4),
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: {press, release, long, repeat, held}
  task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic d, input logic en,
                      input logic [4:0] exp, input string tag);
    reset         = rst;
    bus.db        = d;
    bus.repeat_en = en;
    @(posedge clk);
    #1;
    check_eq(tag, {bus.press_tick, bus.release_tick, bus.long_tick,
                   bus.repeat_tick, bus.held}, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.db = 1'b0;
    bus.repeat_en = 1'b1;

    // 1: short press
    step(1, 0, 1, 5'b00000, "t1_rst0");
    step(1, 0, 1, 5'b00000, "t1_rst1");
    step(0, 0, 1, 5'b00000, "t1_idle");
    step(0, 1, 1, 5'b10001, "t1_e0");
    step(0, 1, 1, 5'b00001, "t1_e1");
    step(0, 1, 1, 5'b00001, "t1_e2");
    step(0, 0, 1, 5'b01000, "t1_rel");
    step(0, 0, 1, 5'b00000, "t1_after");

    // 2: long hold with repeat, db high E0..E20
    for (int k = 0; k <= 20; k++)
      step(0, 1, 1, {k == 0, 1'b0, k == 8, k == 12 || k == 16 || k == 20, 1'b1},
           $sformatf("t2_e%0d", k));
    step(0, 0, 1, 5'b01000, "t2_rel");
    step(0, 0, 1, 5'b00000, "t2_after");

    // 3: held through reset is ignored until released
    step(1, 1, 1, 5'b00000, "t3_rst0");
    step(1, 1, 1, 5'b00000, "t3_rst1");
    for (int k = 0; k < 5; k++)
      step(0, 1, 1, 5'b00000, $sformatf("t3_hold%0d", k));
    step(0, 0, 1, 5'b00000, "t3_low");
    step(0, 1, 1, 5'b10001, "t3_press");
    step(0, 0, 1, 5'b01000, "t3_rel");
    step(0, 0, 1, 5'b00000, "t3_after");

    // 4: release exactly at terminal count
    for (int k = 0; k <= 7; k++)
      step(0, 1, 1, {k == 0, 3'b000, 1'b1}, $sformatf("t4_e%0d", k));
    step(0, 0, 1, 5'b01000, "t4_e8_rel");
    step(0, 0, 1, 5'b00000, "t4_after");

    // 5: repeat disabled until E14, cadence preserved
    for (int k = 0; k <= 20; k++)
      step(0, 1, k >= 14, {k == 0, 1'b0, k == 8, k == 16 || k == 20, 1'b1},
           $sformatf("t5_e%0d", k));
    step(0, 0, 1, 5'b01000, "t5_rel");
    step(0, 0, 1, 5'b00000, "t5_after");

    // 6: reset mid-hold, no release_tick, then WAIT_LOW
    for (int k = 0; k <= 9; k++)
      step(0, 1, 1, {k == 0, 1'b0, k == 8, 1'b0, 1'b1}, $sformatf("t6_e%0d", k));
    step(1, 1, 1, 5'b00000, "t6_rst");
    step(0, 1, 1, 5'b00000, "t6_wl0");
    step(0, 1, 1, 5'b00000, "t6_wl1");
    step(0, 0, 1, 5'b00000, "t6_low");
    step(0, 1, 1, 5'b10001, "t6_pulse_press");
    step(0, 0, 1, 5'b01000, "t6_pulse_rel");
    step(0, 0, 1, 5'b00000, "t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
